// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host-to-device command sequencer with APB register access.
// Optional clock glitch filter: define PS2_HOST_CMD_GLITCH_FILTER_EN.
module ps2_host_cmd_ctrl #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [2:0]  in_pprot,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe,
  output logic        rx_inhibit
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_WAIT_IDLE
  } state_t;

  state_t             state;
  logic [7:0]         tx_byte;
  logic               tx_parity;
  logic [3:0]         bit_cnt;
  logic [3:0]         bit_next;
  logic [INH_W-1:0]   inh_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               tmo_hit;
  logic               ack_ok, nack, timed_out, done;
  logic               busy;
  logic [4:0]         status;

  logic               clk_s1, clk_s2, data_s1, data_s2;
  logic               clk_lvl, clk_prev, fall;

  logic               access, tx_wr;
  logic [1:0]         reg_sel;
  logic               unused_apb;

  assign unused_apb = ^{in_paddr[31:4], in_paddr[1:0], in_pprot, in_pstrb, in_pwdata[31:8]};

  // APB decode; every access completes in its single enable cycle
  assign access     = in_psel & in_penable;
  assign reg_sel    = in_paddr[3:2];
  assign tx_wr      = access & in_pwrite & (reg_sel == 2'd0);
  assign busy       = (state != ST_IDLE);
  assign status     = {done, timed_out, nack, ack_ok, busy};
  assign in_pready  = 1'b1;
  assign in_pslverr = tx_wr & busy;
  assign in_prdata  = (access && !in_pwrite && reg_sel == 2'd1) ? {27'd0, status} : '0;
  assign rx_inhibit = busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

`ifdef PS2_HOST_CMD_GLITCH_FILTER_EN
  logic       clk_filt;
  logic [1:0] flt_cnt;

  // filtered level follows only after 4 consecutive clocks at the new level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
    end else if (clk_s2 != clk_filt) begin
      if (flt_cnt == 2'd3) begin
        clk_filt <= clk_s2;
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + 2'd1;
      end
    end else begin
      flt_cnt <= '0;
    end
  end

  assign clk_lvl = clk_filt;
`else
  assign clk_lvl = clk_s2;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) clk_prev <= 1'b1;
    else       clk_prev <= clk_lvl;
  end

  assign fall     = clk_prev & ~clk_lvl;
  assign bit_next = bit_cnt + 4'd1;
  assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_byte     <= '0;
      tx_parity   <= 1'b0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      tmo_cnt     <= '0;
      ack_ok      <= 1'b0;
      nack        <= 1'b0;
      timed_out   <= 1'b0;
      done        <= 1'b0;
    end else if ((state == ST_RTS || state == ST_SHIFT || state == ST_WAIT_IDLE) && tmo_hit) begin
      // timeout wins over any same-cycle clock edge, including the ACK edge
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      timed_out   <= 1'b1;
      done        <= 1'b1;
      state       <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_wr) begin
            tx_byte    <= in_pwdata[7:0];
            tx_parity  <= ~^in_pwdata[7:0];
            ack_ok     <= 1'b0;
            nack       <= 1'b0;
            timed_out  <= 1'b0;
            done       <= 1'b0;
            ps2_clk_oe <= 1'b1;
            inh_cnt    <= '0;
            state      <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            state       <= ST_RTS;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        ST_RTS: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (fall) begin
            bit_cnt <= bit_next;
            if (bit_next <= 4'd8) begin
              ps2_data_oe <= ~tx_byte[bit_cnt[2:0]];
            end else if (bit_next == 4'd9) begin
              ps2_data_oe <= ~tx_parity;
            end else if (bit_next == 4'd10) begin
              ps2_data_oe <= 1'b0;
            end else begin
              ack_ok <= ~data_s2;
              nack   <= data_s2;
              state  <= ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (clk_s2 && data_s2) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Directed testbench for ps2_host_cmd_ctrl with a PS/2 device BFM.
// Glitch-filter scenario runs when PS2_HOST_CMD_GLITCH_FILTER_EN is defined.
module tb_ps2_host_cmd_ctrl;

  localparam int unsigned INH = 20;
  localparam int unsigned TMO = 600;
`ifdef PS2_HOST_CMD_GLITCH_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_paddr = '0;
  logic        in_psel = 1'b0;
  logic        in_penable = 1'b0;
  logic        in_pwrite = 1'b0;
  logic [2:0]  in_pprot = '0;
  logic [31:0] in_pwdata = '0;
  logic [3:0]  in_pstrb = '1;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;
  logic        ps2_clk_ln, ps2_data_ln;
  logic        ps2_clk_oe, ps2_data_oe, rx_inhibit;
  logic        dev_clk = 1'b1;
  logic        dev_data = 1'b1;

  // open-drain bus: either side may pull low
  assign ps2_clk_ln  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_ln = dev_data & ~ps2_data_oe;

  ps2_host_cmd_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
    .in_pwrite(in_pwrite), .in_pprot(in_pprot), .in_pwdata(in_pwdata),
    .in_pstrb(in_pstrb), .in_pready(in_pready), .in_prdata(in_prdata),
    .in_pslverr(in_pslverr), .ps2_clk(ps2_clk_ln), .ps2_data(ps2_data_ln),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .rx_inhibit(rx_inhibit)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [10:0] rx;
  int          lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
    @(negedge clock);
    in_paddr = addr; in_pwdata = data; in_pwrite = 1'b1;
    in_psel = 1'b1; in_penable = 1'b1;
    #1 err = in_pslverr;
    @(posedge clock);
    #1 in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
    @(negedge clock);
    in_paddr = addr; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b1;
    #1 data = in_prdata; err = in_pslverr;
    @(posedge clock);
    #1 in_psel = 1'b0; in_penable = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(32'h4, d, e);
    check({tag, "_status"}, d, exp);
  endtask

  // write TXDATA from IDLE and verify the inhibit window
  task automatic start_cmd(input string tag, input logic [7:0] b);
    logic e;
    int   k;
    apb_write(32'h0, {24'd0, b}, e);
    check({tag, "_wr_err"}, {31'd0, e}, 32'd0);
    check({tag, "_clk_oe_rise"}, {30'd0, rx_inhibit, ps2_clk_oe}, 32'd3);
    k = 0;
    while (ps2_clk_oe && k < int'(INH) + 10) begin
      @(posedge clock); #1 k++;
    end
    check({tag, "_inhibit_len"}, k, INH);
    check({tag, "_rts_data_oe"}, {31'd0, ps2_data_oe}, 32'd1);
  endtask

  // device BFM: generates nbits clocks, records host bits at each rising edge
  task automatic dev_xfer(input int nbits, input logic ack, input bit glitch, input bit measure);
    rx = '0;
    lat = 0;
    rx[0] = ps2_data_ln;
    for (int i = 1; i <= nbits; i++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clock);
        if (i == 11 && c == 0) dev_data = ack;
        if (glitch && c == 6) dev_clk = 1'b0;
        if (glitch && c == 8) dev_clk = 1'b1;
      end
      @(negedge clock); dev_clk = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        @(posedge clock); #1;
        if (measure && i == 1 && lat == 0 && !ps2_data_oe) lat = c;
      end
      @(negedge clock); dev_clk = 1'b1;
      if (i <= 10) rx[i] = ps2_data_ln;
    end
    if (nbits == 11) begin
      repeat (3) @(negedge clock);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_idle(input string tag, input int max, output int n);
    n = 0;
    while (rx_inhibit && n < max) begin
      @(posedge clock); #1 n++;
    end
    check({tag, "_idle"}, {31'd0, rx_inhibit}, 32'd0);
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] b, input logic ack, input bit glitch);
    int          n;
    logic        par;
    logic [31:0] st;
    par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    dev_xfer(11, ack, glitch, 1'b0);
    check({tag, "_bits"}, {21'd0, rx}, {21'd0, 1'b1, par, b, 1'b0});
    wait_idle(tag, 200, n);
    check({tag, "_oe"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    st = ack ? 32'h14 : 32'h12;
    check_status(tag, st);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          n;

    repeat (3) @(posedge clock);
    #1;
    check("rst_outputs", {27'd0, ps2_clk_oe, ps2_data_oe, rx_inhibit, in_pslverr, in_pready}, 32'd1);
    check("rst_prdata", in_prdata, 32'd0);
    @(negedge clock); reset = 1'b0;
    check_status("rst", 32'd0);
    apb_read(32'hC, d, e);
    check("rd_0c", {d[30:0], e}, 32'd0);
    apb_write(32'h4, 32'hFF, e);
    @(posedge clock); #1;
    check("wr_status_ignored", {30'd0, e, rx_inhibit}, 32'd0);

    // 0xED, ACK from device, plus falling-edge latency
    start_cmd("ed", 8'hED);
    dev_xfer(11, 1'b0, 1'b0, 1'b1);
    check("ed_latency", lat, LAT);
    check("ed_bits", {21'd0, rx}, {21'd0, 11'b1_1_11101101_0});
    wait_idle("ed", 200, n);
    check("ed_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check_status("ed", 32'h12);

    // 0x00 with NACK: parity bit must be 1
    start_cmd("z", 8'h00);
    run_xfer("z", 8'h00, 1'b1, 1'b0);

    // write while busy is rejected and does not disturb the byte
    start_cmd("busy", 8'h5A);
    apb_write(32'h0, 32'h33, e);
    check("busy_slverr", {31'd0, e}, 32'd1);
    check_status("busy_mid", 32'h01);
    run_xfer("busy", 8'h5A, 1'b0, 1'b0);

    // no device clocks: timeout
    start_cmd("tmo", 8'hF4);
    wait_idle("tmo", int'(TMO) + 50, n);
    check("tmo_len", n, TMO);
    check("tmo_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check_status("tmo", 32'h18);

    // reset mid-transfer after 5 device clocks (0x0F bit4=0 keeps data low)
    start_cmd("rstm", 8'h0F);
    dev_xfer(5, 1'b0, 1'b0, 1'b0);
    check("rstm_pre_data_oe", {31'd0, ps2_data_oe}, 32'd1);
    @(negedge clock); reset = 1'b1;
    #1 check("rstm_async", {29'd0, ps2_clk_oe, ps2_data_oe, rx_inhibit}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_status("rstm", 32'd0);
    start_cmd("ff", 8'hFF);
    run_xfer("ff", 8'hFF, 1'b0, 1'b0);

`ifdef PS2_HOST_CMD_GLITCH_FILTER_EN
    start_cmd("glitch", 8'hAA);
    run_xfer("glitch", 8'hAA, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
